nibble_shift_out: RTL and testbench

Parallel-in, serial-out transmitter that drains words previously captured by the design's parallel load registers. Accepts a WIDTH-bit word over a valid/ready handshake, then emits it one bit per enabled cycle with first/last framing. Sits between the register bank and any bit-serial consumer (LED shifter, serial link, test port), forming the read-out end of the load path.

---
 rtl/adl_pkg.sv | 14 +
 rtl/nibble_shift_out.sv | 87 ++++++++
 tb/tb_nibble_shift_out.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/adl_pkg.sv
// Shared definitions for the load/read-out path: FSM states and counter sizing.
package adl_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Bit counter width for a WIDTH-bit frame; never narrower than one bit.
   function automatic int cnt_w(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/nibble_shift_out.sv
// Parallel-in, serial-out transmitter with valid/ready load and first/last framing.
module nibble_shift_out
   import adl_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] inp,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             ser_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_first,
   output logic             ser_last,
   output logic             busy
);

   localparam int CW = cnt_w(WIDTH);

   state_e           state, state_nx;
   logic [WIDTH-1:0] sreg, sreg_nx, sreg_sh;
   logic [CW-1:0]    cnt, cnt_nx;

   // Output decode; first/last are gated by SHIFT so an idle cnt of 0 is not framed.
   always_comb begin
      ser_valid = (state == SHIFT);
      busy      = (state == SHIFT);
      ser_first = (state == SHIFT) && (cnt == '0);
      ser_last  = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
      ser_out   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
      sreg_sh   = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
      // Ready when empty or when the last bit leaves this cycle; never during reset.
      in_ready  = !rst && ((state == IDLE) || (ser_last && ser_en));
   end

   // Next-state: load in IDLE, advance on ser_en, reload back-to-back at frame end.
   always_comb begin
      state_nx = state;
      sreg_nx  = sreg;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (in_valid) begin
               sreg_nx  = inp;
               cnt_nx   = '0;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (ser_en) begin
               if (ser_last) begin
                  if (in_valid) begin
                     sreg_nx = inp;
                     cnt_nx  = '0;
                  end else begin
                     // Fully shifted out, so the zero-filled register is already clear.
                     sreg_nx  = sreg_sh;
                     cnt_nx   = '0;
                     state_nx = IDLE;
                  end
               end else begin
                  sreg_nx = sreg_sh;
                  cnt_nx  = cnt + CW'(1);
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State registers with synchronous reset; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         sreg  <= sreg_nx;
         cnt   <= cnt_nx;
      end
   end

endmodule

// File: tb/tb_nibble_shift_out.sv
// Scoreboard bench: two instances (LSB-first and MSB-first) fed identical stimulus.
module tb_nibble_shift_out;

   localparam int W = 4;

   typedef struct {
      logic b;
      logic f;
      logic l;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] inp;
   logic         in_valid;
   logic         ser_en;
   logic         rdy0, so0, sv0, sf0, sl0, bz0;
   logic         rdy1, so1, sv1, sf1, sl1, bz1;

   int   total = 0;
   int   bad   = 0;
   exp_t q0[$];
   exp_t q1[$];
   logic acc;

   always #5 clk = ~clk;

   nibble_shift_out #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .in_ready(rdy0),
      .ser_en(ser_en), .ser_out(so0), .ser_valid(sv0), .ser_first(sf0),
      .ser_last(sl0), .busy(bz0)
   );

   nibble_shift_out #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .in_ready(rdy1),
      .ser_en(ser_en), .ser_out(so1), .ser_valid(sv1), .ser_first(sf1),
      .ser_last(sl1), .busy(bz1)
   );

   task automatic chk(input string name, input int k, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst%0d t=%0t: got %b want %b", name, k, $time, act, exp);
      end
   endtask

   // Reference: a word becomes WIDTH bits in wire order, framed first..last.
   task automatic push_word(input int k, input logic [W-1:0] w);
      exp_t e;
      for (int i = 0; i < W; i++) begin
         e.b = (k == 0) ? w[i] : w[W-1-i];
         e.f = (i == 0);
         e.l = (i == W - 1);
         if (k == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   // Monitor: pending bits in the queue define valid/busy/ready and the bit shown.
   task automatic mon(input int k, input logic so, input logic sv, input logic sf,
                      input logic sl, input logic bz, input logic ir);
      int   sz;
      exp_t e;
      sz = (k == 0) ? q0.size() : q1.size();
      chk("ser_valid", k, sv, sz != 0);
      chk("busy", k, bz, sz != 0);
      chk("in_ready", k, ir, !rst && (sz == 0 || (sz == 1 && ser_en)));
      if (sz != 0) begin
         e = (k == 0) ? q0[0] : q1[0];
         chk("ser_out", k, so, e.b);
         chk("ser_first", k, sf, e.f);
         chk("ser_last", k, sl, e.l);
         if (ser_en) begin
            if (k == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
         end
      end else begin
         chk("idle_first", k, sf, 1'b0);
         chk("idle_last", k, sl, 1'b0);
      end
      if (rst) begin
         if (k == 0) q0.delete();
         else        q1.delete();
      end
   endtask

   always @(negedge clk) begin
      mon(0, so0, sv0, sf0, sl0, bz0, rdy0);
      mon(1, so1, sv1, sf1, sl1, bz1, rdy1);
   end

   // One cycle: record any handshake after the monitor has run, then move past the edge.
   task automatic step();
      @(negedge clk);
      #1;
      acc = 1'b0;
      if (!rst && in_valid && rdy0) begin push_word(0, inp); acc = 1'b1; end
      if (!rst && in_valid && rdy1) push_word(1, inp);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] w);
      int n;
      inp      = w;
      in_valid = 1'b1;
      n        = 0;
      do begin
         step();
         n++;
      end while (!acc && n < 50);
      if (!acc) begin
         bad++;
         $display("FAIL send_timeout word=%h: accepted=0 want 1", w);
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk_zero_out(input string name);
      @(negedge clk);
      #2;
      chk(name, 0, so0, 1'b0);
      chk(name, 1, so1, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; inp = '0; in_valid = 1'b0; ser_en = 1'b1;
      idle(2);
      rst = 1'b0;
      chk_zero_out("reset_ser_out");
      idle(2);

      // Single word, continuous enable.
      send(4'b1011);
      idle(W + 2);

      // Stall after the first bit.
      send(4'b0110);
      step();
      ser_en = 1'b0;
      idle(3);
      ser_en = 1'b1;
      idle(W + 2);

      // Back-to-back frames with the second word held valid.
      inp = 4'hA; in_valid = 1'b1;
      send(4'hA);
      send(4'h5);
      idle(2 * W + 2);

      // Reset in the middle of a frame, then a normal word.
      send(4'hF);
      step();
      rst = 1'b1;
      in_valid = 1'b1; inp = 4'h3;
      step();
      rst = 1'b0; in_valid = 1'b0;
      chk_zero_out("midreset_ser_out");
      send(4'h9);
      idle(W + 2);

      // Randomized traffic with occasional stalls and resets.
      for (int i = 0; i < 400; i++) begin
         inp      = W'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         ser_en   = ($urandom_range(0, 4) != 0);
         rst      = ($urandom_range(0, 60) == 0);
         step();
      end
      rst = 1'b0; in_valid = 1'b0; ser_en = 1'b1;
      idle(W + 4);

      total++;
      if (q0.size() != 0 || q1.size() != 0) begin
         bad++;
         $display("FAIL drain: pending %0d/%0d want 0/0", q0.size(), q1.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
